// File: rtl/en_wave.sv
// Enemy formation: COUNT enemies in one row that march as a group, bounce
// off the screen edges with a step-down, die when the player missile hits
// them, and fire one round-robin enemy missile at a time. The enemies and
// the enemy missile are overlaid onto the VGA timing/rgb stream in one
// registered stage.
module en_wave #(
  parameter int          COUNT     = 4,
  parameter int          EN_W      = 32,
  parameter int          EN_H      = 32,
  parameter int          GAP       = 16,
  parameter int          X0        = 64,
  parameter int          Y0        = 64,
  parameter int          X_MAX     = 799,
  parameter int          Y_LIMIT   = 520,
  parameter int          STEP_DOWN = 16,
  parameter int          MIS_W     = 4,
  parameter int          MIS_H     = 12,
  parameter int          MIS_SPEED = 4,
  parameter int          RELOAD    = 30,
  parameter logic [11:0] EN_RGB    = 12'hF00,
  parameter logic [11:0] MIS_RGB   = 12'hFF0
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [10:0]      vcount_in,
  input  logic [10:0]      hcount_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  input  logic [11:0]      rgb_in,
  input  logic [10:0]      xpos_missile,
  input  logic [10:0]      ypos_missile,
  input  logic             on_missile,
  input  logic [3:0]       level,
  output logic [10:0]      vcount_out,
  output logic [10:0]      hcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [11:0]      rgb_out,
  output logic [COUNT-1:0] alive,
  output logic             lives,
  output logic             hit,
  output logic             landed,
  output logic [10:0]      xpos_en_missile,
  output logic [10:0]      ypos_en_missile,
  output logic             on_en_missile
);

  localparam int PITCH  = EN_W + GAP;
  localparam int FORM_W = COUNT * EN_W + (COUNT - 1) * GAP;
  localparam int IW     = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int RW     = $clog2(RELOAD + 1);

  typedef enum logic [1:0] {MOVE_R, MOVE_L, FROZEN} form_e;
  typedef enum logic       {M_IDLE, M_FLY}          mis_e;

  // Half-open box test on 12-bit operands so edge sums never wrap.
  function automatic logic in_box(input logic [11:0] px, input logic [11:0] py,
                                  input logic [11:0] bx, input logic [11:0] by,
                                  input int w, input int h);
    return (px >= bx) && (px < bx + 12'(w)) && (py >= by) && (py < by + 12'(h));
  endfunction

  logic             vblnk_prev_q;
  logic             tick;
  logic [10:0]      x_base_q, x_base_d, y_base_q, y_base_d;
  form_e            form_q, form_d;
  logic [COUNT-1:0] alive_q, alive_d;
  logic             landed_q, landed_d, hit_q, hit_d;
  mis_e             mis_q, mis_d;
  logic             mis_on_q, mis_on_d;
  logic [10:0]      mis_x_q, mis_x_d, mis_y_q, mis_y_d;
  logic [RW-1:0]    reload_q, reload_d;
  logic [IW-1:0]    last_q, last_d;
  logic [10:0]      vcount_q, hcount_q;
  logic             vsync_q, vblnk_q, hsync_q, hblnk_q;
  logic [11:0]      rgb_q, rgb_d;

  logic [11:0]      en_x [COUNT];
  logic [COUNT-1:0] kill_mask;
  logic             kill_found;
  logic [10:0]      spd;
  logic [IW-1:0]    pick;
  logic             pick_found;
  logic [11:0]      mis_ny;
  logic             in_en, in_mis;

  assign tick = vblnk_in & ~vblnk_prev_q;

  // Left edge of every enemy slot; dead slots keep their place in the row.
  always_comb begin
    for (int i = 0; i < COUNT; i++) en_x[i] = {1'b0, x_base_q} + 12'(i * PITCH);
  end

  // Player-missile hit: lowest alive enemy containing the missile point,
  // judged against the positions held before this tick's move.
  always_comb begin
    kill_found = 1'b0;
    kill_mask  = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (!kill_found && alive_q[i] &&
          in_box({1'b0, xpos_missile}, {1'b0, ypos_missile}, en_x[i], {1'b0, y_base_q}, EN_W, EN_H)) begin
        kill_found   = 1'b1;
        kill_mask[i] = 1'b1;
      end
    end
    hit_d   = tick & on_missile & kill_found;
    alive_d = hit_d ? (alive_q & ~kill_mask) : alive_q;
  end

  // Formation march: move by spd, bounce with a step-down, freeze on landing.
  always_comb begin
    x_base_d = x_base_q;
    y_base_d = y_base_q;
    form_d   = form_q;
    landed_d = landed_q;
    spd      = (level == 4'd0) ? 11'd1 : {7'd0, level};
    if (tick && (|alive_q) && form_q != FROZEN) begin
      if (form_q == MOVE_R) begin
        if ({1'b0, x_base_q} + 12'(FORM_W - 1) + {1'b0, spd} > 12'(X_MAX)) begin
          y_base_d = y_base_q + 11'(STEP_DOWN);
          form_d   = MOVE_L;
        end else begin
          x_base_d = x_base_q + spd;
        end
      end else begin
        if (x_base_q < spd) begin
          y_base_d = y_base_q + 11'(STEP_DOWN);
          form_d   = MOVE_R;
        end else begin
          x_base_d = x_base_q - spd;
        end
      end
      if ({1'b0, y_base_d} + 12'(EN_H) >= 12'(Y_LIMIT)) begin
        landed_d = 1'b1;
        form_d   = FROZEN;
      end
    end
  end

  // Enemy missile: reload countdown, round-robin shooter pick, then flight.
  always_comb begin
    mis_d      = mis_q;
    mis_on_d   = mis_on_q;
    mis_x_d    = mis_x_q;
    mis_y_d    = mis_y_q;
    reload_d   = reload_q;
    last_d     = last_q;
    pick       = '0;
    pick_found = 1'b0;
    mis_ny     = {1'b0, mis_y_q} + 12'(MIS_SPEED);
    for (int k = 1; k <= COUNT; k++) begin
      if (!pick_found && alive_d[IW'((int'(last_q) + k) % COUNT)]) begin
        pick_found = 1'b1;
        pick       = IW'((int'(last_q) + k) % COUNT);
      end
    end
    if (tick) begin
      if (mis_q == M_IDLE) begin
        reload_d = (reload_q == '0) ? '0 : reload_q - RW'(1);
        if (reload_d == '0 && pick_found) begin
          mis_x_d  = x_base_q + 11'(int'(pick) * PITCH + EN_W / 2 - MIS_W / 2);
          mis_y_d  = y_base_q + 11'(EN_H);
          mis_on_d = 1'b1;
          mis_d    = M_FLY;
          last_d   = pick;
        end
      end else begin
        mis_y_d = mis_ny[10:0];
        if (mis_ny > 12'd599) begin
          mis_on_d = 1'b0;
          mis_d    = M_IDLE;
          reload_d = RW'(RELOAD);
        end
      end
    end
  end

  // Pixel overlay: missile over enemies over the upstream pixel.
  always_comb begin
    in_en = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      if (alive_q[i] && in_box({1'b0, hcount_in}, {1'b0, vcount_in}, en_x[i], {1'b0, y_base_q}, EN_W, EN_H))
        in_en = 1'b1;
    end
    in_mis = mis_on_q &&
             in_box({1'b0, hcount_in}, {1'b0, vcount_in}, {1'b0, mis_x_q}, {1'b0, mis_y_q}, MIS_W, MIS_H);
    if (hblnk_in || vblnk_in) rgb_d = rgb_in;
    else if (in_mis)          rgb_d = MIS_RGB;
    else if (in_en)           rgb_d = EN_RGB;
    else                      rgb_d = rgb_in;
  end

  // Game state registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      x_base_q     <= 11'(X0);
      y_base_q     <= 11'(Y0);
      form_q       <= MOVE_R;
      alive_q      <= '1;
      landed_q     <= 1'b0;
      hit_q        <= 1'b0;
      mis_q        <= M_IDLE;
      mis_on_q     <= 1'b0;
      mis_x_q      <= '0;
      mis_y_q      <= '0;
      reload_q     <= RW'(RELOAD);
      last_q       <= IW'(COUNT - 1);
    end else begin
      vblnk_prev_q <= vblnk_in;
      x_base_q     <= x_base_d;
      y_base_q     <= y_base_d;
      form_q       <= form_d;
      alive_q      <= alive_d;
      landed_q     <= landed_d;
      hit_q        <= hit_d;
      mis_q        <= mis_d;
      mis_on_q     <= mis_on_d;
      mis_x_q      <= mis_x_d;
      mis_y_q      <= mis_y_d;
      reload_q     <= reload_d;
      last_q       <= last_d;
    end
  end

  // Draw stage: timing delayed one cycle alongside the composited pixel.
  always_ff @(posedge pclk) begin
    if (rst) begin
      vcount_q <= '0;
      hcount_q <= '0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      vcount_q <= vcount_in;
      hcount_q <= hcount_in;
      vsync_q  <= vsync_in;
      vblnk_q  <= vblnk_in;
      hsync_q  <= hsync_in;
      hblnk_q  <= hblnk_in;
      rgb_q    <= rgb_d;
    end
  end

  assign vcount_out      = vcount_q;
  assign hcount_out      = hcount_q;
  assign vsync_out       = vsync_q;
  assign vblnk_out       = vblnk_q;
  assign hsync_out       = hsync_q;
  assign hblnk_out       = hblnk_q;
  assign rgb_out         = rgb_q;
  assign alive           = alive_q;
  assign lives           = |alive_q;
  assign hit             = hit_q;
  assign landed          = landed_q;
  assign xpos_en_missile = mis_x_q;
  assign ypos_en_missile = mis_y_q;
  assign on_en_missile   = mis_on_q;

endmodule

// File: tb/tb_en_wave.sv
// Scoreboard bench for en_wave: stimulus pushes expected observations,
// monitors compare them against the DUT at the following falling edge.
module tb_en_wave;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] vcount_in, hcount_in, xpos_missile, ypos_missile;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in, on_missile;
  logic [11:0] rgb_in;
  logic [3:0]  level;
  logic [10:0] vcount_out, hcount_out, xpos_en_missile, ypos_en_missile;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out;
  logic [11:0] rgb_out;
  logic [3:0]  alive;
  logic        lives, hit, landed, on_en_missile;

  localparam int BG = 12'h0A5;
  localparam int EN = 12'hF00;
  localparam int MS = 12'hFF0;

  en_wave dut (
    .pclk(pclk), .rst(rst),
    .vcount_in(vcount_in), .hcount_in(hcount_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .rgb_in(rgb_in),
    .xpos_missile(xpos_missile), .ypos_missile(ypos_missile), .on_missile(on_missile),
    .level(level),
    .vcount_out(vcount_out), .hcount_out(hcount_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .rgb_out(rgb_out), .alive(alive), .lives(lives), .hit(hit), .landed(landed),
    .xpos_en_missile(xpos_en_missile), .ypos_en_missile(ypos_en_missile),
    .on_en_missile(on_en_missile)
  );

  always #5 pclk = ~pclk;

  typedef struct { string name; int sel; int exp; } exp_t;
  exp_t sb[$];
  int   hq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic hit_prev = 1'b0;

  function automatic int dut_val(input int sel);
    case (sel)
      0: return int'(alive);
      1: return int'(lives);
      2: return int'(hit);
      3: return int'(landed);
      4: return int'(on_en_missile);
      5: return int'(xpos_en_missile);
      6: return int'(ypos_en_missile);
      7: return int'(rgb_out);
      8: return int'({vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out});
      default: return -1;
    endcase
  endfunction

  // Scoreboard monitor: drain every expectation queued before this edge.
  always @(negedge pclk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if (dut_val(e.sel) !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h, want %0h", e.name, dut_val(e.sel), e.exp);
      end
    end
  end

  // Hit monitor: each pulse must be expected, one cycle long, with the kill applied.
  always @(negedge pclk) begin
    int ex;
    if (hit === 1'b1) begin
      n_chk++;
      if (hq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_hit: got hit=1 alive=%0h, want no hit", alive);
      end else begin
        ex = hq.pop_front();
        if (int'(alive) !== ex || hit_prev) begin
          n_fail++;
          $display("FAIL hit_pulse: got alive=%0h long=%0b, want alive=%0h long=0", alive, hit_prev, ex);
        end
      end
    end
    hit_prev = hit;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int sel, input int v);
    sb.push_back('{nm, sel, v});
  endtask

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  task automatic tick();
    vblnk_in = 1'b1;
    step();
    vblnk_in = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pix(input string nm, input int h, input int v, input logic hb, input int ex);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hblnk_in  = hb;
    chk(nm, 7, ex);
    step();
    hblnk_in  = 1'b0;
  endtask

  task automatic reset_short();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_alive", 0, 15);
    chk("rst_landed", 3, 0);
    chk("rst_mis_on", 4, 0);
    step();
  endtask

  int mx, my, mdir;
  logic mland;

  initial begin
    rst = 1'b1; vcount_in = '0; hcount_in = '0; vsync_in = 0; vblnk_in = 0;
    hsync_in = 0; hblnk_in = 0; rgb_in = 12'(BG); xpos_missile = '0;
    ypos_missile = '0; on_missile = 0; level = 4'd1;
    step();

    // Reset values with live timing inputs
    hcount_in = 11'd100; vcount_in = 11'd200; hsync_in = 1; vsync_in = 1;
    hblnk_in = 1; rgb_in = 12'hABC;
    chk("rst_timing", 8, 0);        chk("rst_rgb", 7, 0);
    chk("rst_alive", 0, 15);        chk("rst_lives", 1, 1);
    chk("rst_hit", 2, 0);           chk("rst_landed", 3, 0);
    chk("rst_mis_on", 4, 0);        chk("rst_mis_x", 5, 0);
    chk("rst_mis_y", 6, 0);
    step();
    rst = 1'b0; hcount_in = 11'd123; vcount_in = 11'd45; hsync_in = 1;
    vsync_in = 0; hblnk_in = 1; rgb_in = 12'(BG);
    chk("timing_delay", 8, int'({11'd45, 11'd123, 1'b0, 1'b0, 1'b1, 1'b1}));
    chk("blank_passthru", 7, BG);
    step();
    hsync_in = 0; hblnk_in = 0;

    // One tick at level 1 -> x_base 65
    tick();
    chk("t1_alive", 0, 15); chk("t1_lives", 1, 1); chk("t1_mis_on", 4, 0);
    pix("t1_x65", 65, 64, 0, EN);
    pix("t1_x64", 64, 64, 0, BG);
    pix("t1_y63", 65, 63, 0, BG);

    // Level 4 march to the right wall: x reaches 621, bounce, then back to 617
    level = 4'd4;
    ticks(139);
    pix("r_x621", 621, 64, 0, EN);
    pix("r_x620", 620, 64, 0, BG);
    tick();
    pix("bounce_y80", 621, 80, 0, EN);
    pix("bounce_y79", 621, 79, 0, BG);
    tick();
    pix("left_x617", 617, 80, 0, EN);
    pix("left_x616", 616, 80, 0, BG);

    // Kill enemy 1, then no repeat hit, gap miss, inactive missile miss
    reset_short();
    level = 4'd1;
    on_missile = 1; xpos_missile = 11'd117; ypos_missile = 11'd69;
    hq.push_back(4'b1101);
    tick();
    chk("kill_alive", 0, 13); chk("kill_lives", 1, 1); chk("kill_hit_low", 2, 0);
    step();
    tick();
    chk("dead_nohit", 0, 13);
    step();
    xpos_missile = 11'd98; ypos_missile = 11'd70;
    tick();
    chk("gap_nohit", 0, 13);
    step();
    on_missile = 0; xpos_missile = 11'd70;
    tick();
    chk("off_nohit", 0, 13);
    pix("dead_invisible", 118, 70, 0, BG);
    pix("en0_visible", 70, 70, 0, EN);

    // Reload countdown and first shot from enemy 0
    ticks(25);
    chk("t29_mis_off", 4, 0);
    step();
    tick();
    chk("launch_on", 4, 1); chk("launch_x", 5, 107); chk("launch_y", 6, 96);
    step();
    ticks(125);
    chk("fly_on", 4, 1); chk("fly_y596", 6, 596);
    step();
    tick();
    chk("mis_gone", 4, 0);
    step();
    ticks(29);
    chk("reload_wait", 4, 0);
    step();
    tick();
    chk("shot2_on", 4, 1); chk("shot2_x_en2", 5, 359); chk("shot2_y", 6, 96);
    pix("dead1_after", 300, 70, 0, BG);
    pix("en2_visible", 350, 70, 0, EN);

    // Missile overlapping a stepped-down enemy
    reset_short();
    level = 4'd3;
    ticks(29);
    tick();
    chk("d_shot1_x", 5, 165); chk("d_shot1_y", 6, 96);
    step();
    ticks(155);
    level = 4'd1;
    tick();
    chk("d_shot2_on", 4, 1); chk("d_shot2_x", 5, 681); chk("d_shot2_y", 6, 96);
    step();
    level = 4'd15;
    tick();
    chk("d_fly_y", 6, 100);
    pix("mis_over_en", 682, 105, 0, MS);
    pix("mis_hblank", 682, 105, 1, BG);
    pix("en1_body", 670, 90, 0, EN);
    pix("en_above_mis", 682, 99, 0, EN);
    pix("en_right_mis", 685, 105, 0, EN);
    pix("en0_corner", 620, 80, 0, EN);
    pix("en0_left_out", 619, 80, 0, BG);
    pix("en0_top_out", 620, 79, 0, BG);
    pix("en0_right", 651, 80, 0, EN);
    pix("gap_pixel", 652, 80, 0, BG);

    // March down to the landing line at level 15
    reset_short();
    level = 4'd15;
    mx = 64; my = 64; mdir = 0; mland = 1'b0;
    for (int k = 0; k < 3000 && !mland; k++) begin
      tick();
      if (mdir == 0) begin
        if (mx + 175 + 15 > 799) begin my += 16; mdir = 1; end
        else mx += 15;
      end else begin
        if (mx < 15) begin my += 16; mdir = 0; end
        else mx -= 15;
      end
      if (my + 32 >= 520) mland = 1'b1;
      chk("landed_track", 3, int'(mland));
      step();
    end
    pix("land_left", mx, my, 0, EN);
    pix("land_top", mx, my - 1, 0, BG);
    pix("land_right", mx + 175, my, 0, EN);
    pix("land_past", mx + 176, my, 0, BG);
    ticks(5);
    chk("frozen_landed", 3, 1);
    pix("frozen_left", mx, my, 0, EN);
    pix("frozen_top", mx, my - 1, 0, BG);
    pix("frozen_right", mx + 175, my, 0, EN);

    // Reset while the enemy missile is in flight
    for (int k = 0; k < 200 && on_en_missile !== 1'b1; k++) tick();
    n_chk++;
    if (on_en_missile !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_wait: got on=%0b, want 1", on_en_missile);
    end
    rst = 1'b1;
    chk("mrst_alive", 0, 15); chk("mrst_landed", 3, 0); chk("mrst_on", 4, 0);
    chk("mrst_x", 5, 0);      chk("mrst_y", 6, 0);      chk("mrst_rgb", 7, 0);
    step();
    rst = 1'b0;
    step();

    n_chk++;
    if (hq.size() != 0) begin
      n_fail++;
      $display("FAIL missed_hit: got %0d pending, want 0", hq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
